// File: rtl/mul_div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | mul_div_pkg : shared constants for the multi-cycle mul/div unit |
// | rev 1.0                                                         |
// +----------------------------------------------------------------+
package mul_div_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int STEPS     = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_FIX  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Two's-complement magnitude; 0x80..0 maps onto itself, read as unsigned.
  function automatic logic [WIDTH_DEF-1:0] mag(input logic [WIDTH_DEF-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_div_step.sv
`default_nettype none
// +----------------------------------------------------------------+
// | mul_div_step : one shift-add multiply or restoring divide step |
// | rev 1.0                                                         |
// +----------------------------------------------------------------+
module mul_div_step
  import mul_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_hi_i,
  input  logic [WIDTH-1:0] acc_lo_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic [WIDTH-1:0] acc_hi_o,
  output logic [WIDTH-1:0] acc_lo_o
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rsh;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  assign w_sum  = {1'b0, acc_hi_i} + {1'b0, opb_i};
  // Remainder after the left shift needs one extra bit before the trial subtract.
  assign w_rsh  = {acc_hi_i, acc_lo_i[WIDTH-1]};
  assign w_ge   = (w_rsh >= {1'b0, opb_i});
  assign w_diff = w_rsh[WIDTH-1:0] - opb_i;

  always_comb begin
    acc_hi_o = acc_hi_i;
    acc_lo_o = acc_lo_i;
    if (is_div_i) begin
      acc_hi_o = w_ge ? w_diff : w_rsh[WIDTH-1:0];
      acc_lo_o = {acc_lo_i[WIDTH-2:0], w_ge};
    end else if (acc_lo_i[0]) begin
      acc_hi_o = w_sum[WIDTH:1];
      acc_lo_o = {w_sum[0], acc_lo_i[WIDTH-1:1]};
    end else begin
      acc_hi_o = {1'b0, acc_hi_i[WIDTH-1:1]};
      acc_lo_o = {acc_hi_i[0], acc_lo_i[WIDTH-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------+
// | mul_div_unit : multi-cycle MULT/MULTU/DIV/DIVU with HI/LO regs  |
// | rev 1.0                                                         |
// +----------------------------------------------------------------+
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             w_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH-1:0] w_step_hi, w_step_lo;
  logic [2*WIDTH-1:0] w_prod;

  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & in_a[WIDTH-1];
  assign w_b_neg  = w_signed & in_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (~in_a + 1'b1) : in_a;
  assign w_b_mag  = w_b_neg ? (~in_b + 1'b1) : in_b;
  assign w_prod   = neg_q ? (~{acc_hi_q, acc_lo_q} + 1'b1) : {acc_hi_q, acc_lo_q};

  mul_div_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div_q),
    .acc_hi_i (acc_hi_q),
    .acc_lo_i (acc_lo_q),
    .opb_i    (opb_q),
    .acc_hi_o (w_step_hi),
    .acc_lo_o (w_step_lo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_div_d = op[1];
          neg_d    = w_a_neg ^ w_b_neg;
          rneg_d   = w_a_neg;
          dz_d     = op[1] & (in_b == '0);
          cnt_d    = '0;
          acc_hi_d = '0;
          // Divide shifts the dividend out of LO; multiply shifts the multiplier.
          acc_lo_d = op[1] ? w_a_mag : w_b_mag;
          opb_d    = op[1] ? w_b_mag : w_a_mag;
          state_d  = ST_RUN;
        end else begin
          if (hi_we) hi_d = in_a;
          if (lo_we) lo_d = in_a;
        end
      end
      ST_RUN: begin
        acc_hi_d = w_step_hi;
        acc_lo_d = w_step_lo;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (is_div_q) begin
          lo_d = dz_q ? '1 : (neg_q ? (~acc_lo_q + 1'b1) : acc_lo_q);
          hi_d = rneg_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
        end else begin
          hi_d = w_prod[2*WIDTH-1:WIDTH];
          lo_d = w_prod[WIDTH-1:0];
        end
        state_d = ST_DONE;
      end
      default: begin
        if (hi_we) hi_d = in_a;
        if (lo_we) lo_d = in_a;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = (state_q == ST_RUN) || (state_q == ST_FIX);
  assign done = (state_q == ST_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_mul_div_unit : randomized + directed bench for mul_div_unit  |
// | rev 1.0                                                         |
// +----------------------------------------------------------------+
module tb_mul_div_unit;
  import mul_div_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        hi_we;
  logic        lo_we;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .in_a  (in_a),
    .in_b  (in_b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic, truncating division, B=0 convention.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, p, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = 32'h0;
    l = 32'h0;
    case (o)
      OP_MULT: begin
        p = sa * sb;
        up = 64'(p);
        h = up[63:32];
        l = up[31:0];
      end
      OP_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        h = up[63:32];
        l = up[31:0];
      end
      OP_DIV: begin
        if (b == 32'd0) begin
          h = a;
          l = 32'hFFFFFFFF;
        end else begin
          q = sa / sb;
          r = sa % sb;
          up = 64'(q);
          l = up[31:0];
          up = 64'(r);
          h = up[31:0];
        end
      end
      default: begin
        if (b == 32'd0) begin
          h = a;
          l = 32'hFFFFFFFF;
        end else begin
          l = a / b;
          h = a % b;
        end
      end
    endcase
  endtask

  // Launches one op once the unit is idle; inj>=0 pokes start/MTHI at that RUN cycle.
  task automatic op_run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inj, output logic [31:0] h, output logic [31:0] l,
                        output int lat, output int bcnt, output int e);
    int k;
    int w;
    @(negedge clk);
    w = 0;
    while ((busy || done) && w < 80) begin
      @(negedge clk);
      w++;
    end
    start = 1'b1; op = o; in_a = a; in_b = b;
    @(posedge clk);
    e = cyc;
    #1;
    start = 1'b0; in_a = $urandom; in_b = $urandom;
    k = 0; bcnt = 0; lat = -1;
    while (k < 40 && lat < 0) begin
      if (done) lat = k;
      else begin
        if (busy) bcnt++;
        if (k == inj) begin
          start = 1'b1; op = OP_MULTU; in_a = 32'd9; in_b = 32'd7; hi_we = 1'b1;
        end else if (k == inj + 1) begin
          start = 1'b0; hi_we = 1'b0;
        end
        @(posedge clk); #1;
        k++;
      end
    end
    start = 1'b0; hi_we = 1'b0;
    h = hi; l = lo;
  endtask

  task automatic check_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int inj);
    logic [31:0] h, l, eh, el;
    int lat, bcnt, e;
    model(o, a, b, eh, el);
    op_run(o, a, b, inj, h, l, lat, bcnt, e);
    checks++;
    if (lat !== 33) begin
      failures++;
      $display("FAIL %s latency: got %0d want 33", nm, lat);
    end
    checks++;
    if (h !== eh || l !== el) begin
      failures++;
      $display("FAIL %s op=%0d a=%h b=%h: got hi=%h lo=%h want hi=%h lo=%h", nm, o, a, b, h, l, eh, el);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      failures++;
      $display("FAIL reset: got busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
    end
    rst = 1'b0;
  endtask

  task automatic test_timing();
    logic [31:0] h, l;
    int lat, bcnt, e;
    op_run(OP_MULTU, 32'd5, 32'd7, -1, h, l, lat, bcnt, e);
    checks++;
    if (lat !== 33) begin
      failures++;
      $display("FAIL multu_latency: got %0d want 33", lat);
    end
    checks++;
    if (bcnt !== 33) begin
      failures++;
      $display("FAIL busy_cycles: got %0d want 33", bcnt);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_in_done: got %b want 0", busy);
    end
    checks++;
    if (h !== 32'h0 || l !== 32'd35) begin
      failures++;
      $display("FAIL multu_5x7: got hi=%h lo=%h want 0 23", h, l);
    end
  endtask

  task automatic test_mult();
    check_op("mult_m2x3", OP_MULT, 32'hFFFFFFFE, 32'd3, -1);
    check_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
    for (int i = 0; i < 12; i++)
      check_op("mult_rand", 2'($urandom_range(0, 1)), $urandom, $urandom, -1);
  endtask

  task automatic test_div();
    logic [31:0] b;
    check_op("divu_7_2", OP_DIVU, 32'd7, 32'd2, -1);
    check_op("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, -1);
    check_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, -1);
    check_op("divu_zero", OP_DIVU, 32'd4, 32'd0, -1);
    check_op("div_zero_neg", OP_DIV, 32'hFFFFFF00, 32'd0, -1);
    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 300));
        2:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 300));
        default: b = $urandom;
      endcase
      check_op("div_rand", 2'($urandom_range(2, 3)), $urandom, b, -1);
    end
  endtask

  task automatic test_ignore_and_mt();
    check_op("ignore_mid_run", OP_DIVU, 32'd7, 32'd2, 5);
    @(negedge clk);
    lo_we = 1'b1; in_a = 32'hDEADBEEF;
    @(posedge clk); #1;
    lo_we = 1'b0;
    checks++;
    if (lo !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL mtlo: got %h want deadbeef", lo);
    end
    @(negedge clk);
    hi_we = 1'b1; in_a = 32'h12345678;
    @(posedge clk); #1;
    hi_we = 1'b0;
    checks++;
    if (hi !== 32'h12345678 || lo !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL mthi: got hi=%h lo=%h want 12345678 deadbeef", hi, lo);
    end
  endtask

  task automatic test_rst_mid();
    int seen;
    @(negedge clk);
    start = 1'b1; op = OP_MULT; in_a = 32'hFFFFFFF0; in_b = 32'd77;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid: got busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL rst_discard: got %0d active cycles want 0", seen);
    end
    check_op("after_rst_2x4", OP_MULTU, 32'd2, 32'd4, -1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] h, l, eh, el;
    int lat, bcnt, e1, e2;
    op_run(OP_DIV, 32'd100, 32'hFFFFFFFD, -1, h, l, lat, bcnt, e1);
    model(OP_DIV, 32'd100, 32'hFFFFFFFD, eh, el);
    checks++;
    if (h !== eh || l !== el) begin
      failures++;
      $display("FAIL b2b_first: got hi=%h lo=%h want hi=%h lo=%h", h, l, eh, el);
    end
    op_run(OP_MULT, 32'h7FFFFFFF, 32'h80000000, -1, h, l, lat, bcnt, e2);
    model(OP_MULT, 32'h7FFFFFFF, 32'h80000000, eh, el);
    checks++;
    if (e2 - e1 !== 35) begin
      failures++;
      $display("FAIL b2b_period: got %0d want 35", e2 - e1);
    end
    checks++;
    if (h !== eh || l !== el) begin
      failures++;
      $display("FAIL b2b_second: got hi=%h lo=%h want hi=%h lo=%h", h, l, eh, el);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; in_a = 32'h0; in_b = 32'h0;
    hi_we = 1'b0; lo_we = 1'b0;
    test_reset();
    test_timing();
    test_mult();
    test_div();
    test_ignore_and_mt();
    test_rst_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
